// File: rtl/updown_counter_mod.sv
// updown_counter_mod: up/down modulo counter with range, step, prescaler, load, tc and sticky flags.
// Define UDC_SATURATE_EN to add the sat_i port (clamp at the limits instead of wrapping).
module updown_counter_mod #(
  parameter int WIDTH     = 8,
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = 2**WIDTH-1,
  parameter int STEP      = 1,
  parameter int PRESCALE  = 1,
  parameter int RESET_VAL = MIN_VAL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             ud_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             clr_flags_i,
`ifdef UDC_SATURATE_EN
  input  logic             sat_i,
`endif
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             ovf_o,
  output logic             unf_o,
  output logic             at_max_o,
  output logic             at_min_o
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int RANGE = MAX_VAL - MIN_VAL + 1;
  localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] RANGE_X = (WIDTH+1)'(RANGE);
  localparam logic signed [WIDTH:0] MIN_S = (WIDTH+1)'(MIN_VAL);
  localparam logic signed [WIDTH:0] STEP_S = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_q, q_d, up_nxt, dn_nxt, step_nxt, ld_val;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic tc_q, tc_d, ovf_q, ovf_d, unf_q, unf_d;
  logic tick, up_wrap, dn_wrap, wrap, sat;
  logic [WIDTH:0] up_sum;
  logic signed [WIDTH:0] dn_dif;

`ifdef UDC_SATURATE_EN
  assign sat = sat_i;
`else
  assign sat = 1'b0;
`endif

  // Sums are one bit wider than q so a wrap is detected before any truncation.
  always_comb begin
    tick = en_i && pcnt_q == PW'(PRESCALE-1);
    up_sum = {1'b0, q_q} + STEP_X;
    dn_dif = $signed({1'b0, q_q}) - STEP_S;
    up_wrap = up_sum > MAX_X;
    dn_wrap = dn_dif < MIN_S;
    wrap = ud_i ? up_wrap : dn_wrap;
    up_nxt = up_wrap ? WIDTH'(up_sum - RANGE_X) : up_sum[WIDTH-1:0];
    dn_nxt = dn_wrap ? WIDTH'(dn_dif + $signed(RANGE_X)) : dn_dif[WIDTH-1:0];
    step_nxt = (wrap && sat) ? (ud_i ? MAX_W : MIN_W) : (ud_i ? up_nxt : dn_nxt);
    ld_val = {1'b0, load_val_i} > MAX_X ? MAX_W :
             $signed({1'b0, load_val_i}) < MIN_S ? MIN_W : load_val_i;
    q_d = load_i ? ld_val : tick ? step_nxt : q_q;
    pcnt_d = (load_i || tick) ? '0 : en_i ? pcnt_q + 1'b1 : pcnt_q;
    tc_d = !load_i && tick && wrap;
    ovf_d = (tc_d && ud_i) || (ovf_q && !clr_flags_i);
    unf_d = (tc_d && !ud_i) || (unf_q && !clr_flags_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RST_W;
      pcnt_q <= '0;
      tc_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      q_q <= q_d;
      pcnt_q <= pcnt_d;
      tc_q <= tc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign q_o = q_q;
  assign tc_o = tc_q;
  assign ovf_o = ovf_q;
  assign unf_o = unf_q;
  assign at_max_o = q_q == MAX_W;
  assign at_min_o = q_q == MIN_W;
endmodule

// File: tb/tb_updown_counter_mod.sv
// tb_updown_counter_mod: three counter configurations driven in parallel and checked every cycle
// against an arithmetic model, plus directed literal checks; sat tests need UDC_SATURATE_EN.
module tb_updown_counter_mod;
  localparam int P_MIN[3] = '{0, 0, 2};
  localparam int P_MAX[3] = '{9, 9, 13};
  localparam int P_STEP[3] = '{1, 3, 5};
  localparam int P_PS[3] = '{1, 1, 4};
  localparam int P_RV[3] = '{0, 0, 7};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, ud = 1'b0, load = 1'b0, clr = 1'b0, sat = 1'b0;
  logic [7:0] lv = '0;
  logic [7:0] q[3];
  logic tc[3], ovf[3], unf[3], amax[3], amin[3];

  int mq[3], mp[3];
  bit mtc[3], mo[3], mu[3];
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gd
    updown_counter_mod #(
      .WIDTH(8), .MIN_VAL(P_MIN[g]), .MAX_VAL(P_MAX[g]), .STEP(P_STEP[g]),
      .PRESCALE(P_PS[g]), .RESET_VAL(P_RV[g])
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .en_i(en), .ud_i(ud), .load_i(load),
      .load_val_i(lv), .clr_flags_i(clr),
`ifdef UDC_SATURATE_EN
      .sat_i(sat),
`endif
      .q_o(q[g]), .tc_o(tc[g]), .ovf_o(ovf[g]), .unf_o(unf[g]),
      .at_max_o(amax[g]), .at_min_o(amin[g])
    );
  end

  function automatic void chk(string nm, int k, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", nm, k, $time, act, exp);
    end
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k] = P_RV[k];
      mp[k] = 0;
      mtc[k] = 0;
      mo[k] = 0;
      mu[k] = 0;
    end
  endtask

  task automatic model_step(int k);
    int n;
    bit tick, s;
    tick = 0;
`ifdef UDC_SATURATE_EN
    s = sat;
`else
    s = 0;
`endif
    if (clr) begin
      mo[k] = 0;
      mu[k] = 0;
    end
    mtc[k] = 0;
    if (load) begin
      mq[k] = int'(lv) > P_MAX[k] ? P_MAX[k] : int'(lv) < P_MIN[k] ? P_MIN[k] : int'(lv);
      mp[k] = 0;
    end else if (en) begin
      if (mp[k] == P_PS[k] - 1) begin
        mp[k] = 0;
        tick = 1;
      end else mp[k]++;
    end
    if (tick) begin
      n = ud ? mq[k] + P_STEP[k] : mq[k] - P_STEP[k];
      if (n > P_MAX[k] || n < P_MIN[k]) begin
        mtc[k] = 1;
        if (ud) mo[k] = 1;
        else mu[k] = 1;
        if (s) n = ud ? P_MAX[k] : P_MIN[k];
        else n = ud ? n - (P_MAX[k] - P_MIN[k] + 1) : n + (P_MAX[k] - P_MIN[k] + 1);
      end
      mq[k] = n;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
  endtask

  task automatic do_reset(bit check);
    rst_n = 1'b0;
    model_reset();
    #1;
    if (check) begin
      chk("async_rst_q", 0, q[0], 0);
      chk("async_rst_tc", 0, tc[0], 0);
      chk("async_rst_ovf", 0, ovf[0], 0);
      chk("async_rst_unf", 0, unf[0], 0);
      chk("async_rst_q", 2, q[2], 7);
    end
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("q", k, q[k], mq[k]);
      chk("tc", k, tc[k], mtc[k]);
      chk("ovf", k, ovf[k], mo[k]);
      chk("unf", k, unf[k], mu[k]);
      chk("at_max", k, amax[k], mq[k] == P_MAX[k]);
      chk("at_min", k, amin[k], mq[k] == P_MIN[k]);
    end
  end

  initial begin
    int e2[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int e3[4] = '{7, 4, 1, 8};
    int t3[4] = '{1, 0, 0, 1};
    model_reset();
    #12 rst_n = 1'b1;
    en = 1'b1;
    ud = 1'b1;
    repeat (5) cyc();
    chk("pre_rst_q", 0, q[0], 5);
    do_reset(1'b1);
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("up_seq_q", 0, q[0], e2[i]);
      chk("up_seq_tc", 0, tc[0], i == 9);
    end
    chk("up_ovf", 0, ovf[0], 1);
    chk("up_unf", 0, unf[0], 0);
    do_reset(1'b0);
    ud = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("dn_seq_q", 1, q[1], e3[i]);
      chk("dn_seq_tc", 1, tc[1], t3[i]);
    end
    chk("dn_unf", 1, unf[1], 1);
    en = 1'b0;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_unf", 1, unf[1], 0);
    do_reset(1'b0);
    en = 1'b1;
    ud = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("ps_q", 2, q[2], i < 3 ? 7 : i < 7 ? 12 : 5);
      chk("ps_tc", 2, tc[2], i == 7);
    end
    en = 1'b0;
    repeat (3) cyc();
    chk("freeze_q", 2, q[2], 5);
    en = 1'b1;
    load = 1'b1;
    lv = 8'd200;
    cyc();
    chk("ld_hi_q", 0, q[0], 9);
    chk("ld_hi_tc", 0, tc[0], 0);
    chk("ld_hi_q", 2, q[2], 13);
    lv = 8'd1;
    cyc();
    chk("ld_lo_q", 0, q[0], 1);
    chk("ld_lo_q", 2, q[2], 2);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("ld_pcnt_q", 2, q[2], i < 3 ? 2 : 7);
    end
`ifdef UDC_SATURATE_EN
    load = 1'b1;
    lv = 8'd8;
    clr = 1'b1;
    cyc();
    load = 1'b0;
    clr = 1'b0;
    sat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("sat_q", 0, q[0], 9);
      chk("sat_tc", 0, tc[0], i > 0);
    end
    chk("sat_ovf", 0, ovf[0], 1);
    sat = 1'b0;
`endif
    repeat (3000) begin
      en = $urandom_range(0, 3) != 0;
      ud = $urandom_range(0, 1) == 1;
      load = $urandom_range(0, 19) == 0;
      lv = 8'($urandom_range(0, 255));
      clr = $urandom_range(0, 19) == 0;
      sat = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 299) == 0) do_reset(1'b0);
      cyc();
    end
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
